// File: rtl/note_pkg.sv
// note_pkg: shared state encoding, slot record and default geometry for the note lane engine
package note_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;
  typedef struct packed {
    logic       valid;
    logic [9:0] pos;
  } slot_t;
  localparam int DEF_LANES     = 3;
  localparam int DEF_SLOTS     = 5;
  localparam int DEF_SEQ_LEN   = 23;
  localparam int DEF_SPAWN_GAP = 64;
  localparam int DEF_Y_MAX     = 490;
  localparam int DEF_HIT_LO    = 410;
  localparam int DEF_HIT_HI    = 450;
  localparam int DEF_HALF_H    = 20;
  localparam int DEF_LANE_W    = 220;
  localparam int DEF_LANE_GAP  = 20;
endpackage

// File: rtl/note_lane.sv
// note_lane: one lane of note slots with advance, expiry, spawn, hit-select and pixel compare
// Ports:
//   board_clk, reset   clock, asynchronous active-high reset
//   clr_i              clear every slot (entering play)
//   tick_i             gated motion tick
//   spawn_i            spawn a note this tick (already qualified by the top)
//   hit_i              gated hit pulse for this lane
//   pix_x_i, pix_y_i   current VGA pixel
//   expire_cnt_o       slots expired this tick
//   hit_ok_o           a hit cleared a slot this cycle
//   full_o             no free slot left for a spawn this cycle
//   busy_o             at least one slot valid
//   lane_on_o          registered: pixel lies on an active note of this lane
module note_lane
  import note_pkg::*;
#(
  parameter int SLOTS  = DEF_SLOTS,
  parameter int Y_MAX  = DEF_Y_MAX,
  parameter int HIT_LO = DEF_HIT_LO,
  parameter int HIT_HI = DEF_HIT_HI,
  parameter int HALF_H = DEF_HALF_H,
  parameter int X_LO   = 0,
  parameter int X_W    = DEF_LANE_W - DEF_LANE_GAP,
  parameter int CW     = $clog2(SLOTS + 1)
) (
  input  logic          board_clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          tick_i,
  input  logic          spawn_i,
  input  logic          hit_i,
  input  logic [9:0]    pix_x_i,
  input  logic [9:0]    pix_y_i,
  output logic [CW-1:0] expire_cnt_o,
  output logic          hit_ok_o,
  output logic          full_o,
  output logic          busy_o,
  output logic          lane_on_o
);
  localparam logic [9:0] YM  = 10'(Y_MAX);
  localparam logic [9:0] HLO = 10'(HIT_LO);
  localparam logic [9:0] HHI = 10'(HIT_HI);

  slot_t [SLOTS-1:0] slot_q, slot_d;
  logic [SLOTS-1:0]  hit_mask;
  logic              found;
  logic [9:0]        best;
  logic              lane_on_q, lane_on_d;
  logic [10:0]       dx;

  always_comb begin
    found = 1'b0;
    best = '0;
    hit_mask = '0;
    // strict '>' keeps the lowest index on a position tie
    for (int s = 0; s < SLOTS; s++)
      if (slot_q[s].valid && slot_q[s].pos >= HLO && slot_q[s].pos <= HHI && (!found || slot_q[s].pos > best)) begin
        found = 1'b1;
        best = slot_q[s].pos;
        hit_mask = '0;
        hit_mask[s] = 1'b1;
      end
    hit_ok_o = hit_i && found;
    expire_cnt_o = '0;
    slot_d = slot_q;
    // the hit works on pre-tick positions, so a hit slot never advances or expires
    for (int s = 0; s < SLOTS; s++)
      if (hit_ok_o && hit_mask[s])
        slot_d[s].valid = 1'b0;
      else if (tick_i && slot_q[s].valid) begin
        if (slot_q[s].pos >= YM) begin
          slot_d[s].valid = 1'b0;
          expire_cnt_o = expire_cnt_o + CW'(1);
        end else
          slot_d[s].pos = slot_q[s].pos + 10'd1;
      end
    // free slots are judged after this cycle's hit and expiry clears
    full_o = 1'b1;
    for (int s = 0; s < SLOTS; s++)
      if (full_o && !slot_d[s].valid) begin
        full_o = 1'b0;
        if (spawn_i) begin
          slot_d[s].valid = 1'b1;
          slot_d[s].pos = 10'd0;
        end
      end
  end

  // lane-relative x wraps above 1023 when left of the lane, so one compare covers both edges
  assign dx = {1'b0, pix_x_i} - 11'(X_LO);

  always_comb begin
    busy_o = 1'b0;
    lane_on_d = 1'b0;
    // pos-H <= y is rewritten as pos <= y+H so the lower bound cannot underflow
    for (int s = 0; s < SLOTS; s++) begin
      busy_o = busy_o | slot_q[s].valid;
      lane_on_d = lane_on_d | (slot_q[s].valid &&
                  {1'b0, pix_y_i} <= {1'b0, slot_q[s].pos} + 11'(HALF_H) &&
                  {1'b0, slot_q[s].pos} <= {1'b0, pix_y_i} + 11'(HALF_H));
    end
    lane_on_d = lane_on_d && dx < 11'(X_W);
  end

  assign lane_on_o = lane_on_q;

  always_ff @(posedge board_clk or posedge reset)
    if (reset) begin
      slot_q <= '0;
      lane_on_q <= 1'b0;
    end else begin
      slot_q <= clr_i ? '0 : slot_d;
      lane_on_q <= lane_on_d;
    end
endmodule

// File: rtl/note_lane_engine.sv
// note_lane_engine: falling-note rhythm engine with pattern spawning, scoring and per-pixel lane flags
// Ports:
//   board_clk, reset    clock, asynchronous active-high reset
//   step_tick_i         one-cycle motion-rate pulse
//   start_i/stop_i      IDLE->PLAY / PLAY,DONE->IDLE levels
//   pause_i             freezes motion, spawning and hits
//   seq_note_i          pattern word at seq_idx_o, bit l spawns in lane l
//   seq_idx_o           current pattern index
//   hit_btn_i           one-cycle hit pulses per lane
//   pix_x_i, pix_y_i    current VGA pixel
//   lane_on_o, band_on_o  registered pixel flags for notes and hit band
//   score_o, miss_count_o saturating hit / miss counters
//   overflow_o          sticky dropped-spawn flag
//   state_o             IDLE=0, PLAY=1, DONE=2
module note_lane_engine
  import note_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int SLOTS     = DEF_SLOTS,
  parameter int SEQ_LEN   = DEF_SEQ_LEN,
  parameter int SPAWN_GAP = DEF_SPAWN_GAP,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int HIT_LO    = DEF_HIT_LO,
  parameter int HIT_HI    = DEF_HIT_HI,
  parameter int HALF_H    = DEF_HALF_H,
  parameter int LANE_W    = DEF_LANE_W,
  parameter int LANE_GAP  = DEF_LANE_GAP,
  parameter int IW        = $clog2(SEQ_LEN + 1)
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic             step_tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic [LANES-1:0] seq_note_i,
  output logic [IW-1:0]    seq_idx_o,
  input  logic [LANES-1:0] hit_btn_i,
  input  logic [9:0]       pix_x_i,
  input  logic [9:0]       pix_y_i,
  output logic [LANES-1:0] lane_on_o,
  output logic             band_on_o,
  output logic [7:0]       score_o,
  output logic [7:0]       miss_count_o,
  output logic             overflow_o,
  output logic [1:0]       state_o
);
  localparam int GW = SPAWN_GAP > 1 ? $clog2(SPAWN_GAP) : 1;
  localparam int CW = $clog2(SLOTS + 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    seq_idx_q, seq_idx_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [7:0]       score_q, score_d, miss_q, miss_d;
  logic             overflow_q, overflow_d, band_on_q, band_on_d;
  logic             enter_play, active, tick, spawn_tick;
  logic [LANES-1:0] hit_ok, full, busy, spawn;
  logic [CW-1:0]    expire_cnt [LANES];
  logic [9:0]       hit_sum, miss_sum, score_sum, miss_total;

  // stop outranks every other PLAY event, so it also masks this cycle's tick and hits
  assign active = state_q == PLAY && !stop_i && !pause_i;
  assign tick = active && step_tick_i;
  assign spawn_tick = tick && gap_q == '0 && seq_idx_q < IW'(SEQ_LEN);
  assign spawn = spawn_tick ? seq_note_i : '0;
  assign enter_play = state_q == IDLE && start_i;
  assign band_on_d = pix_y_i >= 10'(HIT_LO) && pix_y_i <= 10'(HIT_HI);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_lane #(
      .SLOTS(SLOTS), .Y_MAX(Y_MAX), .HIT_LO(HIT_LO), .HIT_HI(HIT_HI), .HALF_H(HALF_H),
      .X_LO(l * LANE_W), .X_W(LANE_W - LANE_GAP)
    ) u_lane (
      .board_clk(board_clk), .reset(reset), .clr_i(enter_play), .tick_i(tick),
      .spawn_i(spawn[l]), .hit_i(active && hit_btn_i[l]),
      .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
      .expire_cnt_o(expire_cnt[l]), .hit_ok_o(hit_ok[l]), .full_o(full[l]),
      .busy_o(busy[l]), .lane_on_o(lane_on_o[l])
    );
  end

  always_comb begin
    state_d = state_q;
    if (enter_play)
      state_d = PLAY;
    else if (state_q != IDLE && stop_i)
      state_d = IDLE;
    else if (state_q == PLAY && seq_idx_q == IW'(SEQ_LEN) && busy == '0)
      state_d = DONE;
  end

  always_comb begin
    hit_sum = '0;
    miss_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_sum = hit_sum + 10'(hit_ok[l]);
      miss_sum = miss_sum + 10'(expire_cnt[l]);
    end
    score_sum = 10'(score_q) + hit_sum;
    miss_total = 10'(miss_q) + miss_sum;
    score_d = score_sum > 10'd255 ? 8'hff : score_sum[7:0];
    miss_d = miss_total > 10'd255 ? 8'hff : miss_total[7:0];
    gap_d = tick ? (gap_q == GW'(SPAWN_GAP - 1) ? '0 : gap_q + GW'(1)) : gap_q;
    seq_idx_d = seq_idx_q + IW'(spawn_tick);
    overflow_d = overflow_q || (spawn & full) != '0;
    if (enter_play) begin
      score_d = '0;
      miss_d = '0;
      gap_d = '0;
      seq_idx_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge board_clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      seq_idx_q <= '0;
      gap_q <= '0;
      score_q <= '0;
      miss_q <= '0;
      overflow_q <= 1'b0;
      band_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_idx_q <= seq_idx_d;
      gap_q <= gap_d;
      score_q <= score_d;
      miss_q <= miss_d;
      overflow_q <= overflow_d;
      band_on_q <= band_on_d;
    end

  assign state_o = state_q;
  assign seq_idx_o = seq_idx_q;
  assign score_o = score_q;
  assign miss_count_o = miss_q;
  assign overflow_o = overflow_q;
  assign band_on_o = band_on_q;
endmodule

// File: tb/tb_note_lane_engine.sv
// tb_note_lane_engine: directed self-checking bench for note_lane_engine
module tb_note_lane_engine;
  logic       board_clk = 1'b0, reset = 1'b1;
  logic       step_tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [2:0] seq_note, hit_btn = 3'b000, lane_on;
  logic [4:0] seq_idx;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       band_on, overflow;
  logic [7:0] score, miss_count;
  logic [1:0] state;
  logic [2:0] pat [32];
  int         checks = 0, failures = 0;
  int         band_y [4] = '{409, 410, 450, 451};
  int         band_e [4] = '{0, 1, 1, 0};

  always #5 board_clk = ~board_clk;
  assign seq_note = pat[seq_idx];

  note_lane_engine dut (
    .board_clk(board_clk), .reset(reset), .step_tick_i(step_tick), .start_i(start),
    .stop_i(stop), .pause_i(pause), .seq_note_i(seq_note), .seq_idx_o(seq_idx),
    .hit_btn_i(hit_btn), .pix_x_i(pix_x), .pix_y_i(pix_y), .lane_on_o(lane_on),
    .band_on_o(band_on), .score_o(score), .miss_count_o(miss_count),
    .overflow_o(overflow), .state_o(state)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge board_clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    step_tick = 1'b1;
    cyc(n);
    step_tick = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input string tag, input int exp);
    pix_x = 10'(x);
    pix_y = 10'(y);
    cyc(1);
    check(tag, int'(lane_on), exp);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pat[i] = 3'b000;
    pat[0] = 3'b001;
    pat[7] = 3'b010;
    pat[15] = 3'b100;
    cyc(2);
    check("rst_state", int'(state), 0);
    check("rst_idx", int'(seq_idx), 0);
    check("rst_score", int'(score), 0);
    check("rst_miss", int'(miss_count), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_lane_on", int'(lane_on), 0);
    check("rst_band_on", int'(band_on), 0);
    reset = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("enter_play", int'(state), 1);
    // tick 1 spawns lane 0 at pos 0
    run_ticks(1);
    check("spawn_idx", int'(seq_idx), 1);
    probe(10, 0, "pos0_y0", 1);
    probe(10, 20, "pos0_top", 1);
    probe(10, 21, "pos0_out", 0);
    probe(199, 0, "x_edge", 1);
    probe(200, 0, "x_gap", 0);
    run_ticks(300);
    hit_btn = 3'b001;
    cyc(1);
    hit_btn = 3'b000;
    check("hit300_score", int'(score), 0);
    probe(10, 320, "hit300_kept", 1);
    run_ticks(110);
    check("idx_411", int'(seq_idx), 7);
    probe(10, 430, "pos410_in", 1);
    probe(10, 431, "pos410_out", 0);
    pause = 1'b1;
    run_ticks(5);
    pause = 1'b0;
    probe(10, 431, "pause_out", 0);
    probe(10, 430, "pause_in", 1);
    for (int i = 0; i < 4; i++) begin
      pix_y = 10'(band_y[i]);
      cyc(1);
      check("band_on", int'(band_on), band_e[i]);
    end
    run_ticks(20);
    hit_btn = 3'b001;
    cyc(1);
    hit_btn = 3'b000;
    check("hit430_score", int'(score), 1);
    probe(10, 430, "hit430_cleared", 0);
    // lane 1 note spawned at tick 449 reaches 490 at tick 939
    run_ticks(508);
    check("pre_expire_miss", int'(miss_count), 0);
    probe(230, 490, "pos490_lane1", 2);
    run_ticks(1);
    check("expire_miss", int'(miss_count), 1);
    check("expire_score", int'(score), 1);
    check("idx_940", int'(seq_idx), 15);
    probe(230, 490, "expired_gone", 0);
    // lane 2 note spawned at tick 961 reaches 450 at tick 1411
    run_ticks(471);
    check("idx_end", int'(seq_idx), 23);
    check("still_play", int'(state), 1);
    step_tick = 1'b1;
    hit_btn = 3'b100;
    cyc(1);
    step_tick = 1'b0;
    hit_btn = 3'b000;
    check("hit_tick_score", int'(score), 2);
    check("hit_tick_miss", int'(miss_count), 1);
    probe(450, 470, "hit_tick_cleared", 0);
    check("done", int'(state), 2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_idle", int'(state), 0);
    // six full-width spawns overflow five slots per lane
    pat[7] = 3'b000;
    pat[15] = 3'b000;
    for (int i = 0; i < 6; i++) pat[i] = 3'b111;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("replay_state", int'(state), 1);
    check("replay_score", int'(score), 0);
    check("replay_miss", int'(miss_count), 0);
    check("replay_idx", int'(seq_idx), 0);
    run_ticks(320);
    check("ovf_before", int'(overflow), 0);
    run_ticks(1);
    check("ovf_after", int'(overflow), 1);
    check("ovf_idx", int'(seq_idx), 6);
    probe(10, 10, "dropped_spawn", 0);
    probe(450, 64, "lane2_pos64", 4);
    probe(10, 320, "lane0_pos320", 1);
    reset = 1'b1;
    #1;
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    check("mid_rst_idx", int'(seq_idx), 0);
    check("mid_rst_lane_on", int'(lane_on), 0);
    check("mid_rst_score", int'(score), 0);
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
